// File: rtl/qos_wrr_arbiter.sv
// qos_wrr_arbiter: weighted round-robin drain of the four QoS class FIFOs
// (P0..P3) into one downstream stream. Each class gets `weight` pops per turn.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   init, weight0..3    configuration phase request and per-class weights
//   fifo_empty          empty flags of P0..P3 (bit i = Pi)
//   fifo_dataout0..3    FIFO read data, valid the cycle after pop
//   ds_almost_full      downstream back-pressure
//   pop                 one-hot pop strobe to P0..P3
//   data_out, valid_out scheduled word and its qualifier (1-cycle latency)
//   grant_idx           class currently owning the grant
//   active_out,idle_out state indicators
module qos_wrr_arbiter #(
    parameter int DATA_WIDTH   = 12,
    parameter int WEIGHT_WIDTH = 4,
    parameter int DEF_WEIGHT   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [WEIGHT_WIDTH-1:0] weight0,
    input  logic [WEIGHT_WIDTH-1:0] weight1,
    input  logic [WEIGHT_WIDTH-1:0] weight2,
    input  logic [WEIGHT_WIDTH-1:0] weight3,
    input  logic [3:0]              fifo_empty,
    input  logic [DATA_WIDTH-1:0]   fifo_dataout0,
    input  logic [DATA_WIDTH-1:0]   fifo_dataout1,
    input  logic [DATA_WIDTH-1:0]   fifo_dataout2,
    input  logic [DATA_WIDTH-1:0]   fifo_dataout3,
    input  logic                    ds_almost_full,
    output logic [3:0]              pop,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic [1:0]              grant_idx,
    output logic                    active_out,
    output logic                    idle_out
);

    typedef enum logic [1:0] {
        S_RESET,
        S_INIT,
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t state, state_nx;

    logic [WEIGHT_WIDTH-1:0] wgt    [4];
    logic [WEIGHT_WIDTH-1:0] wgt_in [4];
    logic [DATA_WIDTH-1:0]   fdo    [4];

    logic [1:0]              cur, cur_nx, gnt_q, nxt_cls;
    logic [WEIGHT_WIDTH-1:0] credit, credit_nx;
    logic [3:0]              elig;
    logic                    any_elig;
    logic                    pop_any;
    logic                    load_w;

    assign wgt_in[0] = weight0;
    assign wgt_in[1] = weight1;
    assign wgt_in[2] = weight2;
    assign wgt_in[3] = weight3;

    assign fdo[0] = fifo_dataout0;
    assign fdo[1] = fifo_dataout1;
    assign fdo[2] = fifo_dataout2;
    assign fdo[3] = fifo_dataout3;

    // A zero weight parks the class even when its FIFO holds data.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            elig[i] = !fifo_empty[i] && (wgt[i] != '0);
        end
    end

    assign any_elig = |elig;

    // Scan cur+1..cur+3 from the far end so the nearest eligible class
    // wins; fall back to cur itself when no other class qualifies.
    always_comb begin
        nxt_cls = cur;
        for (int k = 3; k >= 1; k--) begin
            logic [1:0] idx;
            idx = cur + 2'(k);
            if (elig[idx]) begin
                nxt_cls = idx;
            end
        end
    end

    assign pop_any = (state == S_ACTIVE) && !init && !fifo_empty[cur]
                     && (credit != '0) && !ds_almost_full;

    assign pop = pop_any ? 4'(4'b0001 << cur) : 4'b0000;

    always_comb begin
        state_nx   = state;
        cur_nx     = cur;
        credit_nx  = credit;
        load_w     = 1'b0;
        active_out = 1'b0;
        idle_out   = 1'b0;
        unique case (state)
            S_RESET: begin
                state_nx = S_INIT;
            end
            S_INIT: begin
                load_w = 1'b1;
                if (!init) begin
                    state_nx = S_IDLE;
                end
            end
            S_IDLE: begin
                idle_out = 1'b1;
                if (init) begin
                    state_nx = S_INIT;
                end else if (any_elig) begin
                    state_nx  = S_ACTIVE;
                    cur_nx    = nxt_cls;
                    credit_nx = wgt[nxt_cls];
                end
            end
            S_ACTIVE: begin
                active_out = 1'b1;
                if (init) begin
                    state_nx  = S_INIT;
                    credit_nx = '0;
                end else if (!any_elig) begin
                    state_nx = S_IDLE;
                end else if (ds_almost_full) begin
                    state_nx = S_ACTIVE;
                end else if (pop_any && (credit > WEIGHT_WIDTH'(1))) begin
                    credit_nx = credit - WEIGHT_WIDTH'(1);
                end else begin
                    // Last credit spent or current FIFO ran dry: rotate.
                    cur_nx    = nxt_cls;
                    credit_nx = wgt[nxt_cls];
                end
            end
            default: begin
                state_nx = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RESET;
            cur       <= '0;
            credit    <= '0;
            gnt_q     <= '0;
            valid_out <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                wgt[i] <= WEIGHT_WIDTH'(DEF_WEIGHT);
            end
        end else begin
            state     <= state_nx;
            cur       <= cur_nx;
            credit    <= credit_nx;
            gnt_q     <= cur;
            valid_out <= pop_any;
            if (load_w) begin
                for (int i = 0; i < 4; i++) begin
                    wgt[i] <= wgt_in[i];
                end
            end
        end
    end

    // FIFO read data arrives one cycle after the pop, so select with the
    // grant registered alongside valid_out.
    always_comb begin
        data_out = '0;
        if (valid_out) begin
            data_out = fdo[gnt_q];
        end
    end

    assign grant_idx = cur;

endmodule

// File: tb/tb_qos_wrr_arbiter.sv
// tb_qos_wrr_arbiter: directed bench for qos_wrr_arbiter with a simple
// behavioural model of the four class FIFOs.
module tb_qos_wrr_arbiter;

    logic        clk;
    logic        reset;
    logic        init;
    logic [3:0]  weight0, weight1, weight2, weight3;
    logic [3:0]  fifo_empty;
    logic [11:0] fifo_dataout0, fifo_dataout1, fifo_dataout2, fifo_dataout3;
    logic        ds_almost_full;
    logic [3:0]  pop;
    logic [11:0] data_out;
    logic        valid_out;
    logic [1:0]  grant_idx;
    logic        active_out;
    logic        idle_out;

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [4][32];
    int          rd  [4] = '{default: 0};
    int          wr  [4] = '{default: 0};
    logic [11:0] fdo [4] = '{default: 12'h000};

    logic [1:0]  t2_cls [16];
    logic [11:0] t2_wd  [16];

    qos_wrr_arbiter #(
        .DATA_WIDTH  (12),
        .WEIGHT_WIDTH(4),
        .DEF_WEIGHT  (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .weight0       (weight0),
        .weight1       (weight1),
        .weight2       (weight2),
        .weight3       (weight3),
        .fifo_empty    (fifo_empty),
        .fifo_dataout0 (fifo_dataout0),
        .fifo_dataout1 (fifo_dataout1),
        .fifo_dataout2 (fifo_dataout2),
        .fifo_dataout3 (fifo_dataout3),
        .ds_almost_full(ds_almost_full),
        .pop           (pop),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .grant_idx     (grant_idx),
        .active_out    (active_out),
        .idle_out      (idle_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pop[i]) begin
                fdo[i] <= mem[i][rd[i]];
                rd[i]  <= rd[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i] = (rd[i] == wr[i]);
        end
    end

    assign fifo_dataout0 = fdo[0];
    assign fifo_dataout1 = fdo[1];
    assign fifo_dataout2 = fdo[2];
    assign fifo_dataout3 = fdo[3];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] p,
                       input logic v, input logic [11:0] d);
        chk({tag, ".pop"}, 32'(pop), 32'(p));
        chk({tag, ".valid"}, 32'(valid_out), 32'(v));
        chk({tag, ".data"}, 32'(data_out), 32'(d));
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [11:0] w);
        mem[c][wr[c]] = w;
        wr[c] = wr[c] + 1;
    endtask

    task automatic set_w(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        weight0 = a;
        weight1 = b;
        weight2 = c;
        weight3 = d;
    endtask

    initial begin
        reset          = 1'b1;
        init           = 1'b1;
        ds_almost_full = 1'b0;
        set_w(4'd2, 4'd1, 4'd1, 4'd1);
        t2_cls = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1,
                   2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
        t2_wd  = '{12'h0FF, 12'h404, 12'h15A, 12'h25A,
                   12'h35A, 12'h895, 12'hCAE, 12'h55A,
                   12'h65A, 12'h75A, 12'h95A, 12'hA5A,
                   12'hB5A, 12'hD5A, 12'hE5A, 12'hF5A};

        // Reset and configuration
        nxt();
        cyc("rst", 4'b0000, 1'b0, 12'h000);
        chk("rst.grant", 32'(grant_idx), 32'd0);
        chk("rst.active", 32'(active_out), 32'd0);
        chk("rst.idle", 32'(idle_out), 32'd0);
        nxt();
        reset = 1'b0;
        #1;
        chk("rststate.idle", 32'(idle_out), 32'd0);
        chk("rststate.active", 32'(active_out), 32'd0);
        nxt();
        chk("init.idle", 32'(idle_out), 32'd0);
        chk("init.active", 32'(active_out), 32'd0);
        chk("init.pop", 32'(pop), 32'd0);
        init = 1'b0;
        nxt();
        chk("idle.idle", 32'(idle_out), 32'd1);
        chk("idle.active", 32'(active_out), 32'd0);

        // Empty skip: only P2 and P3 hold data
        push(2, 12'h2A0); push(2, 12'h2A1);
        push(3, 12'h3B0); push(3, 12'h3B1);
        #1;
        cyc("t3.idle", 4'b0000, 1'b0, 12'h000);
        nxt();
        cyc("t3.c0", 4'b0100, 1'b0, 12'h000);
        chk("t3.grant", 32'(grant_idx), 32'd2);
        nxt();
        cyc("t3.c1", 4'b1000, 1'b1, 12'h2A0);
        nxt();
        cyc("t3.c2", 4'b0100, 1'b1, 12'h3B0);
        nxt();
        cyc("t3.c3", 4'b1000, 1'b1, 12'h2A1);
        nxt();
        cyc("t3.c4", 4'b0000, 1'b1, 12'h3B1);
        chk("t3.active", 32'(active_out), 32'd1);
        nxt();
        cyc("t3.end", 4'b0000, 1'b0, 12'h000);
        chk("t3.idle", 32'(idle_out), 32'd1);
        chk("t3.grant3", 32'(grant_idx), 32'd3);

        // Basic WRR with weights 2,1,1,1; rotation resumes after P3
        for (int k = 0; k < 16; k++) begin
            push(int'(t2_cls[k]), t2_wd[k]);
        end
        #1;
        cyc("t2.idle", 4'b0000, 1'b0, 12'h000);
        nxt();
        chk("t2.active", 32'(active_out), 32'd1);
        chk("t2.grant0", 32'(grant_idx), 32'd0);
        for (int k = 0; k < 16; k++) begin
            cyc($sformatf("t2.k%0d", k), 4'(4'b0001 << t2_cls[k]),
                k > 0, (k > 0) ? t2_wd[(k > 0) ? k - 1 : 0] : 12'h000);
            nxt();
        end
        cyc("t2.tail", 4'b0000, 1'b1, 12'hF5A);
        nxt();
        chk("t2.idle", 32'(idle_out), 32'd1);

        // Back-pressure in the middle of a weight-3 burst on P1
        init = 1'b1;
        set_w(4'd1, 4'd3, 4'd1, 4'd1);
        nxt();
        chk("t4.init", 32'(idle_out | active_out), 32'd0);
        init = 1'b0;
        nxt();
        chk("t4.idle0", 32'(idle_out), 32'd1);
        push(1, 12'h1C0); push(1, 12'h1C1); push(1, 12'h1C2);
        push(2, 12'h2C0);
        #1;
        cyc("t4.idle", 4'b0000, 1'b0, 12'h000);
        nxt();
        cyc("t4.p1a", 4'b0010, 1'b0, 12'h000);
        chk("t4.grant1", 32'(grant_idx), 32'd1);
        nxt();
        ds_almost_full = 1'b1;
        #1;
        cyc("t4.bp0", 4'b0000, 1'b1, 12'h1C0);
        nxt();
        cyc("t4.bp1", 4'b0000, 1'b0, 12'h000);
        nxt();
        cyc("t4.bp2", 4'b0000, 1'b0, 12'h000);
        chk("t4.bpgrant", 32'(grant_idx), 32'd1);
        nxt();
        ds_almost_full = 1'b0;
        #1;
        cyc("t4.r0", 4'b0010, 1'b0, 12'h000);
        nxt();
        cyc("t4.r1", 4'b0010, 1'b1, 12'h1C1);
        nxt();
        cyc("t4.r2", 4'b0100, 1'b1, 12'h1C2);
        chk("t4.grant2", 32'(grant_idx), 32'd2);
        nxt();
        cyc("t4.r3", 4'b0000, 1'b1, 12'h2C0);
        nxt();
        chk("t4.idle", 32'(idle_out), 32'd1);

        // Weight 0 parks P1 even though it holds data
        init = 1'b1;
        set_w(4'd1, 4'd0, 4'd1, 4'd1);
        nxt();
        init = 1'b0;
        nxt();
        chk("t5.idle0", 32'(idle_out), 32'd1);
        push(0, 12'h0E0);
        push(1, 12'h9A0); push(1, 12'h9A1);
        push(2, 12'h2E0);
        #1;
        cyc("t5.idle", 4'b0000, 1'b0, 12'h000);
        nxt();
        cyc("t5.c0", 4'b0001, 1'b0, 12'h000);
        chk("t5.g0", 32'(grant_idx), 32'd0);
        nxt();
        cyc("t5.c1", 4'b0100, 1'b1, 12'h0E0);
        chk("t5.g1", 32'(grant_idx), 32'd2);
        nxt();
        cyc("t5.c2", 4'b0000, 1'b1, 12'h2E0);
        chk("t5.g2", 32'(grant_idx), 32'd2);
        nxt();
        cyc("t5.end", 4'b0000, 1'b0, 12'h000);
        chk("t5.idle", 32'(idle_out), 32'd1);
        nxt();
        chk("t5.stay", 32'(idle_out), 32'd1);
        chk("t5.nopop", 32'(pop), 32'd0);

        // init raised during ACTIVE
        push(0, 12'h0D0); push(0, 12'h0D1); push(0, 12'h0D2);
        #1;
        cyc("t6.idle", 4'b0000, 1'b0, 12'h000);
        nxt();
        cyc("t6.c0", 4'b0001, 1'b0, 12'h000);
        nxt();
        init = 1'b1;
        set_w(4'd2, 4'd2, 4'd1, 4'd1);
        #1;
        cyc("t6.initcyc", 4'b0000, 1'b1, 12'h0D0);
        chk("t6.act", 32'(active_out), 32'd1);
        nxt();
        chk("t6.ininit", 32'(idle_out | active_out), 32'd0);
        cyc("t6.init", 4'b0000, 1'b0, 12'h000);
        init = 1'b0;
        nxt();
        chk("t6.idle1", 32'(idle_out), 32'd1);
        nxt();
        cyc("t6.p1a", 4'b0010, 1'b0, 12'h000);
        chk("t6.g1", 32'(grant_idx), 32'd1);
        nxt();
        cyc("t6.p1b", 4'b0010, 1'b1, 12'h9A0);

        // Reset pulse during ACTIVE drops the pop and the in-flight word
        reset = 1'b1;
        #1;
        cyc("t6.rst", 4'b0000, 1'b0, 12'h000);
        chk("t6.rstact", 32'(active_out), 32'd0);
        chk("t6.rstidle", 32'(idle_out), 32'd0);
        chk("t6.rstgnt", 32'(grant_idx), 32'd0);
        nxt();
        nxt();
        reset = 1'b0;
        init  = 1'b1;
        set_w(4'd1, 4'd1, 4'd1, 4'd1);
        nxt();
        chk("t6.reinit", 32'(idle_out | active_out), 32'd0);
        init = 1'b0;
        nxt();
        chk("t6.idle2", 32'(idle_out), 32'd1);
        cyc("t6.i2", 4'b0000, 1'b0, 12'h000);
        nxt();
        cyc("t6.d0", 4'b0010, 1'b0, 12'h000);
        nxt();
        cyc("t6.d1", 4'b0001, 1'b1, 12'h9A1);
        nxt();
        cyc("t6.d2", 4'b0001, 1'b1, 12'h0D1);
        nxt();
        cyc("t6.d3", 4'b0000, 1'b1, 12'h0D2);
        nxt();
        chk("t6.end", 32'(idle_out), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qos_wrr_arbiter.md
Name: qos_wrr_arbiter

Overview:
- Weighted round-robin scheduler that drains the four per-class output FIFOs (P0..P3) of the QoS block into one downstream 12-bit stream.
- Generates the pop strobes for the four FIFOs and muxes their data out.
- Honours a downstream almost-full back-pressure signal.
- Per-class weights are configured through an init phase, in the same style as the QoS threshold configuration.

Parameters:
DATA_WIDTH, 12, width of FIFO words and data_out
WEIGHT_WIDTH, 4, width of each per-class weight/credit counter
DEF_WEIGHT, 1, weight loaded into all four classes on reset

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
init  input  1  configuration phase request
weight0..weight3  input  WEIGHT_WIDTH each  per-class weight, sampled in INIT
fifo_empty  input  4  empty flags of FIFOs P0..P3 (bit i = Pi)
fifo_dataout0..fifo_dataout3  input  DATA_WIDTH each  FIFO read data; valid the cycle after pop
ds_almost_full  input  1  downstream back-pressure
pop  output  4  one-hot pop strobe to FIFOs P0..P3
data_out  output  DATA_WIDTH  scheduled word
valid_out  output  1  data_out qualifier
grant_idx  output  2  class currently owning the grant
active_out  output  1  high in ACTIVE
idle_out  output  1  high in IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state=RESET.
  - All weight registers = DEF_WEIGHT.
  - cur=0, credit=0, gnt_q=0.
  - pop=0, valid_out=0, data_out=0, grant_idx=0, active_out=0, idle_out=0.
- Eligibility: class i is eligible when fifo_empty[i]==0 and weight_i!=0.
- next(c) = first eligible class scanning c+1, c+2, c+3, c (mod 4).
- States:
  - RESET: the first clock edge with reset low goes to INIT.
  - INIT: weight_i registers load weight0..3 every cycle. init==0 -> IDLE. No pops.
  - IDLE:
    - init==1 -> INIT.
    - Else, if any class is eligible -> ACTIVE, with cur<=next(cur) and credit<=weight[next(cur)].
    - idle_out=1.
  - ACTIVE:
    - active_out=1.
    - init==1 -> INIT. Pop is gated off in that cycle; credit is discarded.
- Pop rule (combinational from registered state): pop[cur]=1 iff state==ACTIVE, init==0, fifo_empty[cur]==0, credit!=0, ds_almost_full==0. All other pop bits are 0. At most one bit is set.
- Credit and rotation in ACTIVE:
  - On a pop with credit>1: credit decrements; cur holds.
  - On a pop with credit==1, or on a cycle where fifo_empty[cur]==1: cur<=next(cur), credit<=weight[next(cur)].
  - If no class is eligible, go to IDLE (cur kept).
  - A switch caused by an empty FIFO costs one bubble cycle.
  - The wrap-around from P3 to P0 is the normal rotation.
- Back-pressure: while ds_almost_full==1, no pop occurs and cur/credit freeze. The word already popped still appears on data_out the next cycle.
- Output datapath, latency 1:
  - valid_out <= |pop and gnt_q <= cur on each edge.
  - data_out = fifo_dataout[gnt_q] when valid_out==1, else 0.
  - grant_idx = cur.
- Weights changed outside INIT have no effect.
- A weight of 0 removes the class from scheduling even if its FIFO is non-empty.
- Simultaneous init==1 and reset==1: reset wins.
- Reset during ACTIVE: pops drop immediately (asynchronous). An in-flight word is lost; valid_out=0.

Test Plan:
1. Reset/config:
   - Stimulus: reset=1 for 2 cycles, then 0; init=1 with weights 2,1,1,1; then init=0.
   - Required: state RESET->INIT->IDLE. All outputs 0 until IDLE, then idle_out=1.
2. Basic WRR:
   - Stimulus: weights 2,1,1,1; all FIFOs hold 4 words (P0: 0FF,404,895,CAE; P1: 15A,55A,...).
   - Required: ACTIVE entered. Pop order P0,P0,P1,P2,P3,P0,P0,...
   - Required: data_out sequence 0FF,404,15A,25A,35A,895,CAE,55A..., each exactly 1 cycle after its pop.
3. Empty skip:
   - Stimulus: only P2 and P3 non-empty; all weights 1.
   - Required: only pop[2] and pop[3] toggle, alternating. After both drain, next edge goes to IDLE; idle_out=1, pop=0.
4. Back-pressure:
   - Stimulus: ds_almost_full=1 for 3 cycles mid-burst on P1 with weight 3 and credit 2.
   - Required: pop=0 for exactly those 3 cycles; the word popped just before still appears with valid_out=1.
   - Required: after release, P1 is popped twice more, then the grant rotates to P2.
5. Weight 0:
   - Stimulus: weight1=0 and P1 non-empty.
   - Required: P1 is never popped; grant_idx never equals 1 while ACTIVE.
6. Mid-operation events:
   - Stimulus: init=1 raised during ACTIVE.
     Required: pop=0 the same cycle; the next edge enters INIT.
   - Stimulus: reset pulse during ACTIVE.
     Required: pop=0 and valid_out=0 immediately; weights return to 1.
